instr_fetch_queue: RTL and testbench

- Consumer end of the program-counter interface.
- Takes each instruction address the PC produces and issues it to the synchronous instruction memory (1-cycle read latency).
- Buffers returned instruction words, each tagged with its address, in a small FIFO.
- Hands instructions to the decoder with a valid/ready handshake, back-pressures the PC, and discards all in-flight and queued work on a taken branch.

---
 rtl/instr_fetch_queue.sv | 114 +++++++++++
 tb/tb_instr_fetch_queue.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Fetch queue between PC and decoder: issues PC addresses to 1-cycle imem, buffers tagged words, flushes on taken branch.
// Latency N+2 (N+1 with FETCH_BYPASS_EN when empty); pc_ready drops when queued+in-flight reaches DEPTH, during flush and clr.
module instr_fetch_queue #(
  parameter int W     = 6,
  parameter int D     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [W-1:0]             pc,
  input  logic                     pc_valid,
  output logic                     pc_ready,
  input  logic                     flush,
  output logic                     imem_en,
  output logic [W-1:0]             imem_addr,
  input  logic [D-1:0]             imem_data,
  output logic [D-1:0]             instr,
  output logic [W-1:0]             instr_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [D-1:0]  data_mem [DEPTH];
  logic [W-1:0]  addr_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic          inflight;
  logic [W-1:0]  tag;

  logic          fifo_empty;
  logic [CW:0]   reserved;
  logic          accept;
  logic          bypass;
  logic          push;
  logic          pop;

  assign fifo_empty = (cnt == '0);
  // The outstanding read already owns a slot, so the FIFO can never overflow.
  assign reserved   = {1'b0, cnt} + (CW+1)'(inflight);
  assign pc_ready   = !clr && !flush && (reserved < DEPTH_C);
  assign accept     = pc_valid && pc_ready;
  assign imem_en    = accept;
  assign imem_addr  = pc;

`ifdef FETCH_BYPASS_EN
  assign bypass = fifo_empty && inflight && !flush && instr_ready;
`else
  assign bypass = 1'b0;
`endif

  assign push        = inflight && !flush && !bypass;
  assign pop         = !fifo_empty && instr_ready;
  assign instr_valid = !fifo_empty || bypass;
  assign count       = cnt;

  always_comb begin
    instr    = '0;
    instr_pc = '0;
    if (bypass) begin
      instr    = imem_data;
      instr_pc = tag;
    end else if (!fifo_empty) begin
      instr    = data_mem[rd_ptr];
      instr_pc = addr_mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      inflight <= 1'b0;
      tag      <= '0;
    end else begin
      inflight <= accept;
      if (accept) begin
        tag <= pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr && push) begin
      data_mem[wr_ptr] <= imem_data;
      addr_mem[wr_ptr] <= tag;
    end
  end

  // A pop during flush is honoured by the decoder; the clear simply wins over the pointer update.
  always_ff @(posedge clk) begin
    if (clr || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: model queue of accepted addresses, checked against decoder-side output.
module tb_instr_fetch_queue;

  localparam int W     = 6;
  localparam int D     = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            clr;
  logic [W-1:0]    pc;
  logic            pc_valid;
  logic            pc_ready;
  logic            flush;
  logic            imem_en;
  logic [W-1:0]    imem_addr;
  logic [D-1:0]    imem_data = '0;
  logic [D-1:0]    instr;
  logic [W-1:0]    instr_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  instr_fetch_queue #(.W(W), .D(D), .DEPTH(DEPTH)) dut (
    .clk(clk), .clr(clr), .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .flush(flush), .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .count(count)
  );

  function automatic logic [D-1:0] word_of(input logic [W-1:0] a);
    return 32'h1000 + D'(a);
  endfunction

  // Synchronous instruction memory, one-cycle read latency.
  always @(posedge clk) if (imem_en) imem_data <= word_of(imem_addr);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: addresses accepted but not yet delivered (queued + in flight).
  logic [W-1:0] exp_q[$];
  logic         prev_acc = 1'b0;
  bit           mon_en = 1'b0;
  int           n_del = 0;
  int           fcnt;
  logic         exp_rdy, exp_acc, exp_vld;
  logic [W-1:0] front;

  always @(negedge clk) if (mon_en) begin
    fcnt    = exp_q.size() - (prev_acc ? 1 : 0);
    exp_rdy = !clr && !flush && (exp_q.size() < DEPTH);
    exp_acc = pc_valid && exp_rdy;
    exp_vld = (fcnt != 0);
`ifdef FETCH_BYPASS_EN
    if (fcnt == 0 && prev_acc && !flush && instr_ready) exp_vld = 1'b1;
`endif
    chk("pc_ready", 64'(pc_ready), 64'(exp_rdy));
    chk("imem_en", 64'(imem_en), 64'(exp_acc));
    if (exp_acc) chk("imem_addr", 64'(imem_addr), 64'(pc));
    chk("count", 64'(count), 64'(fcnt));
    chk("instr_valid", 64'(instr_valid), 64'(exp_vld));
    if (exp_vld && instr_ready && exp_q.size() > 0) begin
      front = exp_q.pop_front();
      n_del++;
      chk("instr_pc", 64'(instr_pc), 64'(front));
      chk("instr", 64'(instr), 64'(word_of(front)));
    end
    if (clr || flush) exp_q.delete();
    if (exp_acc) exp_q.push_back(pc);
    prev_acc = exp_acc;
  end

  int n_acc = 0;

  // One stimulus cycle; the PC advances only after its address was accepted.
  task automatic cyc(input logic v, input logic rdy, input logic fl);
    logic a;
    pc_valid    = v;
    instr_ready = rdy;
    flush       = fl;
    @(negedge clk);
    a = pc_valid && pc_ready;
    @(posedge clk);
    #1;
    if (a) begin
      pc = pc + W'(1);
      n_acc++;
    end
  endtask

  initial begin
    int k, d0;
    clr = 1'b1; pc_valid = 1'b1; pc = '0; flush = 1'b0; instr_ready = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_instr_pc", 64'(instr_pc), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    @(posedge clk); #1;
    clr = 1'b0;

    // Streaming
    pc = '0; n_acc = 0;
    for (int i = 0; i < 10 && n_acc < 4; i++) cyc(1'b1, 1'b1, 1'b0);
    chk("stream_accepts", 64'(n_acc), 64'd4);
    repeat (4) cyc(1'b0, 1'b1, 1'b0);

    // Fill to DEPTH, then one pop reopens pc_ready a cycle later
    pc = '0; n_acc = 0;
    repeat (10) cyc(1'b1, 1'b0, 1'b0);
    chk("fill_accepts", 64'(n_acc), 64'd4);
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_pc_held", 64'(pc), 64'd4);
    cyc(1'b1, 1'b1, 1'b0);
    chk("fill_pop_no_accept", 64'(pc), 64'd4);
    cyc(1'b1, 1'b0, 1'b0);
    chk("fill_refill_pc4", 64'(pc), 64'd5);
    repeat (8) cyc(1'b0, 1'b1, 1'b0);

    // Flush with a read in flight
    pc = 6'd5; n_acc = 0;
    for (int i = 0; i < 10 && n_acc < 3; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(instr_valid), 64'd0);
    pc = 6'd20;
    cyc(1'b1, 1'b1, 1'b0);
    repeat (4) cyc(1'b0, 1'b1, 1'b0);

    // Flush together with a pop
    pc = 6'd30; n_acc = 0;
    for (int i = 0; i < 10 && n_acc < 2; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("fpop_count_before", 64'(count), 64'd2);
    cyc(1'b0, 1'b1, 1'b1);
    chk("fpop_count_after", 64'(count), 64'd0);
    repeat (3) cyc(1'b0, 1'b1, 1'b0);

    // Back-to-back flushes
    pc = 6'd40;
    repeat (3) cyc(1'b1, 1'b1, 1'b1);
    chk("b2b_pc_held", 64'(pc), 64'd40);
    cyc(1'b1, 1'b1, 1'b0);
    repeat (4) cyc(1'b0, 1'b1, 1'b0);

    // Wrap-around with 2-cycle decoder stalls
    pc = '0; n_acc = 0; k = 0; d0 = n_del;
    while (k < 80 && (n_acc < 10 || exp_q.size() > 0)) begin
      cyc(pc < 6'd10, ((k / 2) % 2) == 0, 1'b0);
      k++;
    end
    chk("wrap_delivered", 64'(n_del - d0), 64'd10);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic fl;
      fl = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 199) == 0) clr = 1'b1;
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, fl);
      clr = 1'b0;
      if (fl) pc = W'($urandom);
    end
    repeat (10) cyc(1'b0, 1'b1, 1'b0);
    chk("drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
